operand_b_stage: RTL and testbench
==================================

# operand_b_stage

Parametrised stage-2 → stage-3 operand-B selector and pipeline register for the pipelined datapath. Picks ALU operand B from register read data, an extended immediate, or zero. Resolves stage-3/stage-4 forwarding on the register path and extends the immediate per a mode field. The result is registered into stage 3 with stall, flush and valid handling, plus a saturating forwarding-event counter for performance debug.

## Interface
- DATA_WIDTH, 32, operand/data width
- IMM_WIDTH, 16, raw immediate width; must be < DATA_WIDTH
- REG_ADDR_WIDTH, 5, register-file address width
- CNT_WIDTH, 16, forwarding counter width

Clocking is fixed: one clock, Clk; reset Reset is synchronous and active-high.

- Clk  in  1  clock, rising edge
- Reset  in  1  synchronous active-high reset
- S2_Valid  in  1  stage-2 holds a real instruction
- S2_ReadData2  in  DATA_WIDTH  register-file port-2 data
- S2_Imm  in  IMM_WIDTH  raw immediate
- S2_DataSource  in  2  00 register, 01 immediate, 10 zero, 11 treated as register
- S2_ExtMode  in  2  00 sign, 01 zero, 10 upper (Imm << (DATA_WIDTH-IMM_WIDTH)), 11 treated as sign
- S2_Rt  in  REG_ADDR_WIDTH  source register of ReadData2
- S3_WriteEn / S3_WriteReg / S3_AluResult  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  forwarding source, stage 3
- S4_WriteEn / S4_WriteReg / S4_WriteData  in  1 / REG_ADDR_WIDTH / DATA_WIDTH  forwarding source, stage 4
- Stall  in  1  hold stage-3 register
- Flush  in  1  insert bubble
- S3_OperandB  out  DATA_WIDTH  registered ALU operand B
- S3_StoreData  out  DATA_WIDTH  registered forwarded register value, independent of DataSource
- S3_Valid  out  1  registered valid
- S3_FwdSel  out  2  registered: 00 none, 01 stage 3, 10 stage 4
- FwdCount  out  CNT_WIDTH  saturating count of forwarded accepted instructions

## Operation
- Forwarding (combinational, stage 2):
  - Stage-3 hit: S3_WriteEn, S3_WriteReg==S2_Rt, S2_Rt!=0.
  - Stage-4 hit: same terms on the S4_ signals.
  - Stage 3 has priority over stage 4.
  - Otherwise S2_ReadData2 is used.
- Register 0 is never forwarded.
- Immediate extension:
  - Sign: replicate Imm[IMM_WIDTH-1].
  - Zero: pad with 0s.
  - Upper: Imm in the MSBs, low bits 0.
- Forwarding never affects the immediate or zero path. S3_StoreData always carries the forwarded register value.
- Register update priority per edge, highest first: Reset, Flush, Stall, load.
  - Reset: every output and FwdCount go to 0.
  - Flush: S3_Valid, S3_OperandB, S3_StoreData and S3_FwdSel go to 0. FwdCount holds. Flush overrides a simultaneous Stall.
  - Stall: all registers hold, including FwdCount. Forwarding inputs are ignored.
  - Load: capture the stage-2 results. S3_Valid = S2_Valid.
- FwdCount increments on a load edge with S2_Valid=1 and any forwarding hit. This applies even when DataSource selects the immediate, because the store path still uses the forwarded value. FwdCount saturates at all-ones.
- When S2_Valid=0 on a load, data is still captured and FwdSel is reported, but FwdCount does not increment.

## Timing
- Latency: 1 cycle from stage-2 inputs to S3_ outputs. No combinational path from inputs to outputs.
- The stall window may be any length. Outputs stay stable throughout.
- Reset asserted mid-stall or mid-flush: the next edge clears all registers. The first load occurs on the first edge with Reset=0 and Stall=0.
- Counter wrap: none. It holds at 2^CNT_WIDTH−1.

## Structure
- Shared package pipeline_pkg holds the DataSource encodings (SRC_REG, SRC_IMM, SRC_ZERO), ExtMode encodings (EXT_SIGN, EXT_ZERO, EXT_UPPER) and FwdSel encodings (FWD_NONE, FWD_S3, FWD_S4). Hazard and control blocks reuse them.
- One sub-module, imm_extend: purely combinational, parameters IMM_WIDTH/DATA_WIDTH, inputs Imm and ExtMode.
- Forwarding compare, mux, stage register and counter live in operand_b_stage.

## Test plan
Defaults DATA_WIDTH=32, IMM_WIDTH=16.

- **Immediate extension:** Imm=16'h8001, source imm.
  - Sign → S3_OperandB=32'hFFFF8001, S3_Valid=1 one cycle later.
  - Zero → 32'h00008001.
  - Upper → 32'h80010000.
- **Forward priority:** Rt=5, ReadData2=32'h1111, stage 3 writes reg 5 with 32'hAAAA, stage 4 writes reg 5 with 32'hBBBB, source reg → OperandB=32'hAAAA, FwdSel=01, FwdCount=1.
  - Same with stage 3 disabled → 32'hBBBB, FwdSel=10.
- **Register-0 guard:** Rt=0, ReadData2=0, both stages writing reg 0 with 32'hDEAD → OperandB=0, FwdSel=00, FwdCount unchanged.
- **Immediate plus store forward:** source imm, Imm=16'h0004, sign, Rt=7, stage 3 writes reg 7 with 32'h55 → OperandB=32'h4, StoreData=32'h55.
- **Stall, flush and reset:**
  - Load 32'h1234, then Stall for 3 cycles with changing inputs → outputs hold 32'h1234.
  - Stall and Flush together → Valid=0, OperandB=0.
  - Reset mid-stream → all outputs and FwdCount=0 next edge.
- **Counter saturation:** CNT_WIDTH=4, 20 consecutive valid forwarded loads → FwdCount=4'hF and holds.
  - A stalled forwarded cycle does not increment.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline encodings: operand-B source, immediate extension mode and
// forwarding source. The hazard and control blocks use the same names.
package pipeline_pkg;

  typedef enum logic [1:0] {
    SRC_REG  = 2'b00,
    SRC_IMM  = 2'b01,
    SRC_ZERO = 2'b10
  } data_src_e;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'b00,
    EXT_ZERO  = 2'b01,
    EXT_UPPER = 2'b10
  } ext_mode_e;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_S3   = 2'b01,
    FWD_S4   = 2'b10
  } fwd_sel_e;

endpackage : pipeline_pkg

// File: rtl/imm_extend.sv
// Purely combinational immediate extender: sign, zero or upper placement.
// Mode 2'b11 is handled as sign extension.
module imm_extend
  import pipeline_pkg::*;
#(
  parameter int IMM_WIDTH  = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic [IMM_WIDTH-1:0]  Imm,
  input  logic [1:0]            ExtMode,
  output logic [DATA_WIDTH-1:0] ImmExt
);

  localparam int PAD_WIDTH = DATA_WIDTH - IMM_WIDTH;

  // Select the extended immediate for the requested mode.
  always_comb begin
    // NOTE: the output gets a default before the case so that every path
    // assigns it; a missing assignment would infer a latch.
    ImmExt = {{PAD_WIDTH{Imm[IMM_WIDTH-1]}}, Imm};
    case (ExtMode)
      EXT_ZERO:  ImmExt = {{PAD_WIDTH{1'b0}}, Imm};
      EXT_UPPER: ImmExt = {Imm, {PAD_WIDTH{1'b0}}};
      default:   ;
    endcase
  end

endmodule : imm_extend

// File: rtl/operand_b_stage.sv
// Stage-2 to stage-3 operand-B selection and pipeline register.
// Resolves register forwarding (stage 3 before stage 4, never register 0),
// chooses register/immediate/zero for operand B, registers the result with
// stall, flush and valid handling, and counts forwarded instructions.
module operand_b_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int IMM_WIDTH      = 16,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      S2_Valid,
  input  logic [DATA_WIDTH-1:0]     S2_ReadData2,
  input  logic [IMM_WIDTH-1:0]      S2_Imm,
  input  logic [1:0]                S2_DataSource,
  input  logic [1:0]                S2_ExtMode,
  input  logic [REG_ADDR_WIDTH-1:0] S2_Rt,
  input  logic                      S3_WriteEn,
  input  logic [REG_ADDR_WIDTH-1:0] S3_WriteReg,
  input  logic [DATA_WIDTH-1:0]     S3_AluResult,
  input  logic                      S4_WriteEn,
  input  logic [REG_ADDR_WIDTH-1:0] S4_WriteReg,
  input  logic [DATA_WIDTH-1:0]     S4_WriteData,
  input  logic                      Stall,
  input  logic                      Flush,
  output logic [DATA_WIDTH-1:0]     S3_OperandB,
  output logic [DATA_WIDTH-1:0]     S3_StoreData,
  output logic                      S3_Valid,
  output logic [1:0]                S3_FwdSel,
  output logic [CNT_WIDTH-1:0]      FwdCount
);

  logic                  s3_hit;
  logic                  s4_hit;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] reg_value;
  logic [DATA_WIDTH-1:0] operand_b;
  logic [1:0]            fwd_sel;
  logic                  load;

  imm_extend #(
    .IMM_WIDTH  (IMM_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imm_extend (
    .Imm     (S2_Imm),
    .ExtMode (S2_ExtMode),
    .ImmExt  (imm_ext)
  );

  assign s3_hit = S3_WriteEn && (S3_WriteReg == S2_Rt) && (S2_Rt != '0);
  assign s4_hit = S4_WriteEn && (S4_WriteReg == S2_Rt) && (S2_Rt != '0);
  assign load   = !Flush && !Stall;

  // Forwarded register value (stage 3 wins) and operand-B source mux.
  always_comb begin
    reg_value = S2_ReadData2;
    fwd_sel   = FWD_NONE;
    if (s3_hit) begin
      reg_value = S3_AluResult;
      fwd_sel   = FWD_S3;
    end else if (s4_hit) begin
      reg_value = S4_WriteData;
      fwd_sel   = FWD_S4;
    end

    operand_b = reg_value;
    case (S2_DataSource)
      SRC_IMM:  operand_b = imm_ext;
      SRC_ZERO: operand_b = '0;
      default:  ;
    endcase
  end

  // Stage-3 register: reset, then flush bubble, then stall hold, then load.
  always_ff @(posedge Clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      S3_OperandB  <= '0;
      S3_StoreData <= '0;
      S3_Valid     <= 1'b0;
      S3_FwdSel    <= FWD_NONE;
    end else if (Flush) begin
      S3_OperandB  <= '0;
      S3_StoreData <= '0;
      S3_Valid     <= 1'b0;
      S3_FwdSel    <= FWD_NONE;
    end else if (!Stall) begin
      S3_OperandB  <= operand_b;
      S3_StoreData <= reg_value;
      S3_Valid     <= S2_Valid;
      S3_FwdSel    <= fwd_sel;
    end
  end

  // Saturating count of valid instructions accepted with a forwarding hit.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FwdCount <= '0;
    end else if (load && S2_Valid && (fwd_sel != FWD_NONE) && (FwdCount != '1)) begin
      FwdCount <= FwdCount + 1'b1;
    end
  end

endmodule : operand_b_stage

// File: tb/tb_operand_b_stage.sv
// Directed bench for operand_b_stage. Counter width is reduced to 4 bits so
// saturation is reachable in a short run.
module tb_operand_b_stage;
  import pipeline_pkg::*;

  localparam int DW = 32;
  localparam int IW = 16;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          S2_Valid;
  logic [DW-1:0] S2_ReadData2;
  logic [IW-1:0] S2_Imm;
  logic [1:0]    S2_DataSource;
  logic [1:0]    S2_ExtMode;
  logic [AW-1:0] S2_Rt;
  logic          S3_WriteEn;
  logic [AW-1:0] S3_WriteReg;
  logic [DW-1:0] S3_AluResult;
  logic          S4_WriteEn;
  logic [AW-1:0] S4_WriteReg;
  logic [DW-1:0] S4_WriteData;
  logic          Stall;
  logic          Flush;
  logic [DW-1:0] S3_OperandB;
  logic [DW-1:0] S3_StoreData;
  logic          S3_Valid;
  logic [1:0]    S3_FwdSel;
  logic [CW-1:0] FwdCount;

  int total = 0;
  int bad   = 0;

  operand_b_stage #(
    .DATA_WIDTH     (DW),
    .IMM_WIDTH      (IW),
    .REG_ADDR_WIDTH (AW),
    .CNT_WIDTH      (CW)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .S2_Valid      (S2_Valid),
    .S2_ReadData2  (S2_ReadData2),
    .S2_Imm        (S2_Imm),
    .S2_DataSource (S2_DataSource),
    .S2_ExtMode    (S2_ExtMode),
    .S2_Rt         (S2_Rt),
    .S3_WriteEn    (S3_WriteEn),
    .S3_WriteReg   (S3_WriteReg),
    .S3_AluResult  (S3_AluResult),
    .S4_WriteEn    (S4_WriteEn),
    .S4_WriteReg   (S4_WriteReg),
    .S4_WriteData  (S4_WriteData),
    .Stall         (Stall),
    .Flush         (Flush),
    .S3_OperandB   (S3_OperandB),
    .S3_StoreData  (S3_StoreData),
    .S3_Valid      (S3_Valid),
    .S3_FwdSel     (S3_FwdSel),
    .FwdCount      (FwdCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling outputs.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    S2_Valid      = 1'b1;
    S2_ReadData2  = '0;
    S2_Imm        = '0;
    S2_DataSource = SRC_REG;
    S2_ExtMode    = EXT_SIGN;
    S2_Rt         = '0;
    S3_WriteEn    = 1'b0;
    S3_WriteReg   = '0;
    S3_AluResult  = '0;
    S4_WriteEn    = 1'b0;
    S4_WriteReg   = '0;
    S4_WriteData  = '0;
    Stall         = 1'b0;
    Flush         = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [DW-1:0] opb, input logic [DW-1:0] st,
                           input logic vld, input logic [1:0] sel, input logic [CW-1:0] cnt);
    check({tag, ".opb"},   S3_OperandB, opb);
    check({tag, ".store"}, S3_StoreData, st);
    check({tag, ".valid"}, {31'd0, S3_Valid}, {31'd0, vld});
    check({tag, ".sel"},   {30'd0, S3_FwdSel}, {30'd0, sel});
    check({tag, ".cnt"},   {28'd0, FwdCount}, {28'd0, cnt});
  endtask

  initial begin
    idle_inputs();
    S2_ReadData2 = 32'hCAFE_F00D;
    S2_Rt        = 5'd9;
    S3_WriteEn   = 1'b1;
    S3_WriteReg  = 5'd9;
    Reset        = 1'b1;
    step();
    check_all("reset", 32'h0, 32'h0, 1'b0, FWD_NONE, 4'd0);
    Reset = 1'b0;

    // Immediate extension modes on 16'h8001.
    idle_inputs();
    S2_Imm        = 16'h8001;
    S2_DataSource = SRC_IMM;
    S2_ExtMode    = EXT_SIGN;
    step();
    check_all("imm_sign", 32'hFFFF_8001, 32'h0, 1'b1, FWD_NONE, 4'd0);
    S2_ExtMode = EXT_ZERO;
    step();
    check("imm_zero", S3_OperandB, 32'h0000_8001);
    S2_ExtMode = EXT_UPPER;
    step();
    check("imm_upper", S3_OperandB, 32'h8001_0000);
    S2_ExtMode = 2'b11;
    step();
    check("imm_mode3", S3_OperandB, 32'hFFFF_8001);

    // Forward priority: stage 3 beats stage 4.
    idle_inputs();
    S2_Rt        = 5'd5;
    S2_ReadData2 = 32'h1111;
    S3_WriteEn   = 1'b1;
    S3_WriteReg  = 5'd5;
    S3_AluResult = 32'hAAAA;
    S4_WriteEn   = 1'b1;
    S4_WriteReg  = 5'd5;
    S4_WriteData = 32'hBBBB;
    step();
    check_all("fwd_s3", 32'hAAAA, 32'hAAAA, 1'b1, FWD_S3, 4'd1);
    S3_WriteEn = 1'b0;
    step();
    check_all("fwd_s4", 32'hBBBB, 32'hBBBB, 1'b1, FWD_S4, 4'd2);
    S4_WriteReg = 5'd6;
    step();
    check_all("fwd_miss", 32'h1111, 32'h1111, 1'b1, FWD_NONE, 4'd2);

    // Register 0 is never forwarded.
    idle_inputs();
    S3_WriteEn   = 1'b1;
    S3_AluResult = 32'hDEAD;
    S4_WriteEn   = 1'b1;
    S4_WriteData = 32'hDEAD;
    step();
    check_all("reg0", 32'h0, 32'h0, 1'b1, FWD_NONE, 4'd2);

    // Immediate operand while the store path carries the forwarded value.
    idle_inputs();
    S2_DataSource = SRC_IMM;
    S2_Imm        = 16'h0004;
    S2_Rt         = 5'd7;
    S3_WriteEn    = 1'b1;
    S3_WriteReg   = 5'd7;
    S3_AluResult  = 32'h55;
    S2_ReadData2  = 32'h99;
    step();
    check_all("imm_store", 32'h4, 32'h55, 1'b1, FWD_S3, 4'd3);

    // Invalid instruction: data and FwdSel captured, no count.
    S2_Valid = 1'b0;
    step();
    check_all("invalid_fwd", 32'h4, 32'h55, 1'b0, FWD_S3, 4'd3);

    // Zero source and the 2'b11 register alias.
    idle_inputs();
    S2_DataSource = SRC_ZERO;
    S2_Rt         = 5'd3;
    S2_ReadData2  = 32'h77;
    step();
    check_all("src_zero", 32'h0, 32'h77, 1'b1, FWD_NONE, 4'd3);
    S2_DataSource = 2'b11;
    S2_ReadData2  = 32'h99;
    step();
    check("src_alias", S3_OperandB, 32'h99);

    // Stall holds everything, even with forwarding hits presented.
    idle_inputs();
    S2_Rt        = 5'd1;
    S2_ReadData2 = 32'h1234;
    step();
    check_all("pre_stall", 32'h1234, 32'h1234, 1'b1, FWD_NONE, 4'd3);
    Stall        = 1'b1;
    S3_WriteEn   = 1'b1;
    S3_WriteReg  = 5'd1;
    for (int i = 0; i < 3; i++) begin
      S2_ReadData2 = 32'h5000 + i;
      S3_AluResult = 32'hF000 + i;
      S2_Valid     = i[0];
      step();
      check_all("stall", 32'h1234, 32'h1234, 1'b1, FWD_NONE, 4'd3);
    end

    // Flush overrides stall; counter holds.
    S2_Valid = 1'b1;
    Flush    = 1'b1;
    step();
    check_all("flush", 32'h0, 32'h0, 1'b0, FWD_NONE, 4'd3);

    // Release and load a forwarded instruction.
    Stall = 1'b0;
    Flush = 1'b0;
    S3_AluResult = 32'hF00D;
    step();
    check_all("post_flush", 32'hF00D, 32'hF00D, 1'b1, FWD_S3, 4'd4);

    // Reset while stalled clears all state.
    Stall = 1'b1;
    Reset = 1'b1;
    step();
    check_all("reset_mid", 32'h0, 32'h0, 1'b0, FWD_NONE, 4'd0);
    Reset = 1'b0;
    Stall = 1'b0;

    // Saturation: 20 valid forwarded loads.
    idle_inputs();
    S2_Rt       = 5'd2;
    S4_WriteEn  = 1'b1;
    S4_WriteReg = 5'd2;
    for (int i = 0; i < 20; i++) begin
      S4_WriteData = 32'h100 + i;
      step();
      if (i == 13) check("cnt_14", {28'd0, FwdCount}, 32'd14);
    end
    check_all("sat", 32'h113, 32'h113, 1'b1, FWD_S4, 4'hF);
    Stall = 1'b1;
    step();
    check("sat_stall", {28'd0, FwdCount}, 32'hF);
    Stall = 1'b0;
    step();
    check("sat_hold", {28'd0, FwdCount}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_operand_b_stage
